// File: rtl/seq_addsub_flags_pkg.sv
// seq_addsub_flags_pkg: FSM state encoding and WIDTH/CHUNK legality check shared by the adder.
`ifndef SEQ_ADDSUB_FLAGS_PKG_SV
`define SEQ_ADDSUB_FLAGS_PKG_SV
`define SAF_LEGAL(w, c) ((c) >= 1 && (c) <= (w) && (w) >= 2 && ((w) % (c)) == 0)
package seq_addsub_flags_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage
`endif

// File: rtl/seq_addsub_flags_adder_chunk.sv
// seq_addsub_flags_adder_chunk: combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module seq_addsub_flags_adder_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);
   logic [CHUNK:0] c;
   assign c[0] = cin;
   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign cout = c[CHUNK];
endmodule

// File: rtl/seq_addsub_flags.sv
// seq_addsub_flags: multi-cycle add/sub processing CHUNK bits per cycle, with registered condition flags.
module seq_addsub_flags
   import seq_addsub_flags_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             zero,
   output logic             sign,
   output logic             parity,
   output logic             overflow
);
   localparam int N  = WIDTH / CHUNK;
   localparam int IW = N > 1 ? $clog2(N) : 1;
   if (!`SAF_LEGAL(WIDTH, CHUNK)) begin : g_illegal
      $error("seq_addsub_flags: WIDTH must be >= 2 and a multiple of CHUNK");
   end
   state_t           state, state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] ra, rb, acc, acc_nxt;
   logic [CHUNK-1:0] cs;
   logic             cy, cout, last;
   assign last = idx == IW'(N - 1);
   assign busy = state == RUN;
   assign done = state == DONE;
   seq_addsub_flags_adder_chunk #(.CHUNK(CHUNK)) u_adder_chunk (
      .a    (ra[idx*CHUNK +: CHUNK]),
      .b    (rb[idx*CHUNK +: CHUNK]),
      .cin  (cy),
      .sum  (cs),
      .cout (cout)
   );
   always_comb begin
      acc_nxt                     = acc;
      acc_nxt[idx*CHUNK +: CHUNK] = cs;
   end
   always_comb state_nxt = state == IDLE ? (start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
   always_ff @(posedge clk)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   // Flags are captured from the completed accumulator on the final step, so outputs never show partial sums.
   always_ff @(posedge clk)
      if (!rst_n) begin
         idx      <= '0;
         sum      <= '0;
         carry    <= 1'b0;
         zero     <= 1'b0;
         sign     <= 1'b0;
         parity   <= 1'b0;
         overflow <= 1'b0;
      end else if (state == IDLE && start) begin
         ra  <= a;
         rb  <= b ^ {WIDTH{sub}};
         cy  <= sub;
         idx <= '0;
      end else if (state == RUN) begin
         acc <= acc_nxt;
         cy  <= cout;
         idx <= idx + 1'b1;
         if (last) begin
            sum      <= acc_nxt;
            carry    <= cout;
            zero     <= acc_nxt == '0;
            sign     <= acc_nxt[WIDTH-1];
            parity   <= ~^acc_nxt;
            overflow <= (ra[WIDTH-1] == rb[WIDTH-1]) && (acc_nxt[WIDTH-1] != ra[WIDTH-1]);
         end
      end
endmodule

// File: tb/tb_seq_addsub_flags.sv
// tb_seq_addsub_flags: directed vectors with a queued scoreboard for 16/4 and 32/8 configurations.
module tb_seq_addsub_flags;
   typedef struct {
      logic [31:0] sum;
      logic [4:0]  f;
      int          t0;
   } exp_t;
   exp_t q16[$], q32[$];
   logic        clk = 0, rst_n = 0, start = 0, sub = 0, start32 = 0, sub32 = 0;
   logic [15:0] a = 0, b = 0, sum;
   logic [31:0] a32 = 0, b32 = 0, sum32;
   logic        busy, done, carry, zero, sign, parity, overflow;
   logic        busy32, done32, carry32, zero32, sign32, parity32, overflow32;
   int          cyc = 0, vecs = 0, errs = 0, dones16 = 0, pushed16 = 0, dones32 = 0;

   seq_addsub_flags u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .carry(carry), .zero(zero),
      .sign(sign), .parity(parity), .overflow(overflow)
   );
   seq_addsub_flags #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .sum(sum32), .carry(carry32), .zero(zero32),
      .sign(sign32), .parity(parity32), .overflow(overflow32)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   exp_t e16, e32;
   always @(negedge clk) if (done) begin
      dones16++;
      if (q16.size() == 0) begin
         vecs++;
         errs++;
         $display("FAIL done16_spurious: got done=1 at cycle %0d expected no done", cyc);
      end else begin
         e16 = q16.pop_front();
         chk("latency16", cyc - e16.t0, 5);
         chk("sum16", {16'h0, sum}, e16.sum);
         chk("flags16_czspo", {27'h0, carry, zero, sign, parity, overflow}, {27'h0, e16.f});
      end
   end
   always @(negedge clk) if (done32) begin
      dones32++;
      if (q32.size() == 0) begin
         vecs++;
         errs++;
         $display("FAIL done32_spurious: got done=1 at cycle %0d expected no done", cyc);
      end else begin
         e32 = q32.pop_front();
         chk("latency32", cyc - e32.t0, 5);
         chk("sum32", sum32, e32.sum);
         chk("flags32_czspo", {27'h0, carry32, zero32, sign32, parity32, overflow32}, {27'h0, e32.f});
      end
   end

   task automatic push16(logic [15:0] es, logic [4:0] f);
      q16.push_back('{sum: {16'h0, es}, f: f, t0: cyc});
      pushed16++;
   endtask

   task automatic wait_done16();
      int k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         vecs++;
         errs++;
         $display("FAIL done16_timeout: got no done in 20 cycles expected done");
      end
   endtask

   task automatic run16(logic s, logic [15:0] x, logic [15:0] y, logic [15:0] es, logic [4:0] f);
      start = 1; sub = s; a = x; b = y;
      push16(es, f);
      @(posedge clk); #1;
      start = 0;
      wait_done16();
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs16", {9'h0, busy, done, sum, carry, zero, sign, parity, overflow}, 0);
      rst_n = 1;
      @(posedge clk); #1;
      chk("idle_outs16", {9'h0, busy, done, sum, carry, zero, sign, parity, overflow}, 0);
      // flags packed as {carry, zero, sign, parity, overflow}
      run16(0, 16'h0000, 16'h0000, 16'h0000, 5'b01010);
      run16(0, 16'hFFFF, 16'h0001, 16'h0000, 5'b11010);
      run16(0, 16'h7FFF, 16'h0001, 16'h8000, 5'b00101);
      run16(1, 16'h0005, 16'h0007, 16'hFFFE, 5'b00100);
      // stray starts during RUN (cycle 2) and DONE (cycle 5) must be ignored
      start = 1; sub = 0; a = 16'h1234; b = 16'h4321;
      push16(16'h5555, 5'b00010);
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1; start = 1; a = 16'hFFFF; b = 16'hFFFF;
      chk("busy_run", {31'h0, busy}, 1);
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1;
      @(posedge clk); #1; start = 1;
      @(posedge clk); #1; start = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("busy_after", {31'h0, busy}, 0);
      chk("sum_hold", {16'h0, sum}, 32'h5555);
      // reset asserted in cycle 3 aborts the operation
      start = 1; sub = 1; a = 16'h1234; b = 16'h0001;
      @(posedge clk); #1; start = 0;
      @(posedge clk); #1;
      @(posedge clk); #1; rst_n = 0;
      @(posedge clk); #1; rst_n = 1;
      chk("abort_outs16", {9'h0, busy, done, sum, carry, zero, sign, parity, overflow}, 0);
      repeat (8) @(posedge clk);
      #1;
      run16(1, 16'h8000, 16'h0001, 16'h7FFF, 5'b10001);
      run16(1, 16'h0003, 16'h0003, 16'h0000, 5'b11010);
      chk("done_count16", dones16, pushed16);
      start32 = 1; sub32 = 1; a32 = 32'h8000_0000; b32 = 32'h0000_0001;
      q32.push_back('{sum: 32'h7FFF_FFFF, f: 5'b10001, t0: cyc});
      @(posedge clk); #1; start32 = 0;
      repeat (12) @(posedge clk);
      #1;
      chk("done_count32", dones32, 1);
      chk("queue16_empty", q16.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/seq_addsub_flags.md
# seq_addsub_flags

Parametrised multi-cycle adder/subtractor with a condition-flag register. It processes a WIDTH-bit operation CHUNK bits per cycle through a ripple-carry chunk adder under a start/done handshake. It produces sum, carry, zero, sign, parity and overflow flags with the same semantics as the existing 16-bit flag adder. It sits in the datapath wherever a narrow, area-cheap arithmetic unit with status flags is needed.

## Interface

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK, ≥ 2
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only in IDLE
- sub  input  1  0 = a+b, 1 = a−b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse: result and flags valid
- sum  output  WIDTH  result
- carry  output  1  carry out of MSB; for sub, 1 = no borrow
- zero  output  1  sum == 0
- sign  output  1  sum[WIDTH-1]
- parity  output  1  even parity, ~^sum
- overflow  output  1  signed overflow of the effective operation

## Operation

- N = WIDTH/CHUNK chunk steps. States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a, b XOR {WIDTH{sub}}, carry-in = sub; clear chunk index; go RUN.
  - start=0 → stay.
- RUN: each cycle add chunk[idx] of both latched operands plus the running carry, write the CHUNK result bits into the internal accumulator, update the running carry, idx++.
  - After step N-1 → DONE.
  - sum and flags are copied from the accumulator on the same edge.
- DONE: done=1 for exactly one cycle, then unconditionally → IDLE. start is ignored in DONE.
- start while busy or done is ignored. No queueing; a, b and sub are don't-care.
- Output flags:
  - overflow = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is the inverted operand for sub.
  - carry is the raw final carry.
- sum and flags hold their values until the next operation completes. They never show partial results.
- Arithmetic is modulo 2^WIDTH.

## Timing

- Reset, taking priority over everything:
  - state=IDLE, idx=0.
  - busy=0, done=0, sum=0, carry=0, zero=0, sign=0, parity=0, overflow=0.
- Reset mid-RUN aborts the operation. No done is produced and outputs take their reset values.
- Start accepted at edge 0. busy is high during cycles 1..N. done and the final outputs are visible in cycle N+1, so latency is N+1 cycles.
- Throughput: one operation per N+2 cycles. The earliest next start is the cycle after done.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package holds the state encoding constants (IDLE/RUN/DONE) and the WIDTH%CHUNK legality check macro.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder (a, b, cin → sum, cout) built from full-adder cells. Instantiate it once and reuse it every cycle.
- Chunk index counter width = clog2(N), minimum 1.
- Elaboration-time error if WIDTH%CHUNK ≠ 0.

## Test plan

Defaults are WIDTH=16, CHUNK=4, N=4, so done occurs in cycle 5.

- add 0000+0000 → sum=0000, zero=1, parity=1, carry=0, sign=0, overflow=0; done exactly in cycle 5.
- add FFFF+0001 → sum=0000, carry=1, zero=1, parity=1, overflow=0.
- add 7FFF+0001 → sum=8000, sign=1, overflow=1, carry=0, parity=0.
- sub 0005−0007 → sum=FFFE, carry=0 (borrow), sign=1, overflow=0, parity=0.
- Busy and reset handling:
  - start pulsed in cycles 2 and 5 of an active operation is ignored; outputs show only the first result.
  - rst_n=0 in cycle 3 → no done, all outputs 0; the next start completes normally.
- WIDTH=32, CHUNK=8: sub 80000000−00000001 → sum=7FFFFFFF, overflow=1, carry=1, sign=0, parity=0; done in cycle 5.
